// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types for the ADPLL acquisition/lock controller: lock and brake
// state encodings plus small elaboration-time helpers.
package pll_lock_sequencer_pkg;

    typedef enum logic [1:0] {
        UNLOCKED           = 2'd0,
        COARSE_FREQ_LOCKED = 2'd1,
        FINE_FREQ_LOCKED   = 2'd2,
        PHASE_LOCKED       = 2'd3
    } lock_state_t;

    typedef enum logic [1:0] {
        BRAKES_OFF = 2'd0,
        BRAKING    = 2'd1,
        RECOVERING = 2'd2
    } brake_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Error-sample inputs and DCO-code / status outputs of the lock sequencer,
// bundled so the error detectors and DCO side connect as one port.
interface pll_lock_sequencer_if #(
    parameter int FERR_W   = 12,
    parameter int PERR_W   = 8,
    parameter int COARSE_W = 6,
    parameter int FINE_W   = 8
) ();
    import pll_lock_sequencer_pkg::*;

    logic                       en;
    logic                       err_valid;
    logic signed [FERR_W-1:0]   ferr;
    logic signed [PERR_W-1:0]   perr;
    logic        [COARSE_W-1:0] coarse_code;
    logic        [FINE_W-1:0]   fine_code;
    lock_state_t                lock_state;
    brake_state_t               brake_state;
    logic                       locked;
    logic                       unlock_pulse;

    modport master (
        output en, err_valid, ferr, perr,
        input  coarse_code, fine_code, lock_state, brake_state, locked, unlock_pulse
    );

    modport slave (
        input  en, err_valid, ferr, perr,
        output coarse_code, fine_code, lock_state, brake_state, locked, unlock_pulse
    );

endinterface

// File: rtl/pll_lock_sequencer_tol_run_counter.sv
// Magnitude-vs-tolerance compare feeding a saturating run counter of
// consecutive in-tolerance samples; done_o flags the qualifying sample.
module tol_run_counter #(
    parameter int MAG_W    = 13,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clr_i,
    input  logic             sample_i,
    input  logic [MAG_W-1:0] mag_i,
    input  logic [MAG_W-1:0] tol_i,
    output logic             done_o
);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_tol;

    assign in_tol = (mag_i <= tol_i);

    // Combinational so the owning FSM can advance on the same edge the run completes.
    assign done_o = sample_i && in_tol && (cnt_q >= CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (sample_i) begin
            if (!in_tol)
                cnt_d = '0;
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// ADPLL acquisition and lock controller: steps coarse/fine DCO codes from
// frequency/phase error samples, walks the lock states, brakes on overshoot.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int FERR_W       = 12,
    parameter int PERR_W       = 8,
    parameter int COARSE_W     = 6,
    parameter int FINE_W       = 8,
    parameter int LOCK_CNT     = 4,
    parameter int COARSE_TOL   = 8,
    parameter int FINE_TOL     = 1,
    parameter int PHASE_TOL    = 2,
    parameter int LOSS_TOL     = 16,
    parameter int BRAKE_CYCLES = 3
) (
    input  logic                 refclk,
    input  logic                 resetn,
    pll_lock_sequencer_if.slave  bus
);
    localparam int MAG_W  = max_int(FERR_W, PERR_W) + 1;
    localparam int CODE_W = max_int(COARSE_W, FINE_W);
    localparam int BC_W   = $clog2(BRAKE_CYCLES + 1);

    localparam logic [COARSE_W-1:0] COARSE_MID = {1'b1, {(COARSE_W-1){1'b0}}};
    localparam logic [FINE_W-1:0]   FINE_MID   = {1'b1, {(FINE_W-1){1'b0}}};
    localparam logic [BC_W-1:0]     BRAKE_LAST = BC_W'(BRAKE_CYCLES - 1);

    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] v);
        return (v < 0) ? MAG_W'(-v) : MAG_W'(v);
    endfunction

    function automatic logic [CODE_W-1:0] sat_step(
        input logic [CODE_W-1:0] code,
        input logic [CODE_W-1:0] top,
        input logic              up,
        input logic              dn
    );
        if (up && code != top) return code + 1'b1;
        if (dn && code != '0)  return code - 1'b1;
        return code;
    endfunction

    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [FINE_W-1:0]   fine_q, fine_d;
    lock_state_t         lock_q, lock_d;
    brake_state_t        brake_q, brake_d;
    logic [BC_W-1:0]     brake_cnt_q, brake_cnt_d;
    logic                alt_q, alt_d;
    logic                sign_vld_q, sign_vld_d;
    logic                sign_neg_q, sign_neg_d;
    logic                locked_q, locked_d;
    logic                pulse_q, pulse_d;

    // One extra bit so the most negative input has a representable magnitude.
    logic signed [MAG_W-1:0] ferr_s, perr_s;
    logic [MAG_W-1:0]        ferr_mag, perr_mag, run_mag, run_tol;
    logic                    ferr_nz, ferr_neg, ferr_pos, perr_neg, perr_pos;
    logic                    reversal, sample, run_done, run_clr, coarse_go;

    assign ferr_s   = MAG_W'(bus.ferr);
    assign perr_s   = MAG_W'(bus.perr);
    assign ferr_mag = abs_mag(ferr_s);
    assign perr_mag = abs_mag(perr_s);
    assign ferr_nz  = (bus.ferr != '0);
    assign ferr_neg = ferr_s[MAG_W-1];
    assign ferr_pos = ferr_nz && !ferr_neg;
    assign perr_neg = perr_s[MAG_W-1];
    assign perr_pos = (bus.perr != '0) && !perr_neg;
    assign reversal = ferr_nz && sign_vld_q && (ferr_neg != sign_neg_q);
    assign sample   = bus.en && bus.err_valid;

    always_comb begin
        run_mag = ferr_mag;
        run_tol = MAG_W'(COARSE_TOL);
        case (lock_q)
            COARSE_FREQ_LOCKED: run_tol = MAG_W'(FINE_TOL);
            FINE_FREQ_LOCKED, PHASE_LOCKED: begin
                run_mag = perr_mag;
                run_tol = MAG_W'(PHASE_TOL);
            end
            default: ;
        endcase
    end

    assign run_clr = !bus.en || (lock_d != lock_q);

    tol_run_counter #(
        .MAG_W    (MAG_W),
        .LOCK_CNT (LOCK_CNT)
    ) u_run (
        .clk_i    (refclk),
        .resetn_i (resetn),
        .clr_i    (run_clr),
        .sample_i (sample),
        .mag_i    (run_mag),
        .tol_i    (run_tol),
        .done_o   (run_done)
    );

    always_comb begin
        coarse_d    = coarse_q;
        fine_d      = fine_q;
        lock_d      = lock_q;
        brake_d     = brake_q;
        brake_cnt_d = brake_cnt_q;
        alt_d       = alt_q;
        sign_vld_d  = sign_vld_q;
        sign_neg_d  = sign_neg_q;
        pulse_d     = 1'b0;
        coarse_go   = 1'b0;

        if (!bus.en) begin
            lock_d      = UNLOCKED;
            brake_d     = BRAKES_OFF;
            brake_cnt_d = '0;
            alt_d       = 1'b0;
        end else if (bus.err_valid) begin
            if (ferr_nz) begin
                sign_vld_d = 1'b1;
                sign_neg_d = ferr_neg;
            end
            // Loss of lock outranks any advance or step from the same sample.
            if (lock_q != UNLOCKED && ferr_mag > MAG_W'(LOSS_TOL)) begin
                lock_d      = UNLOCKED;
                fine_d      = FINE_MID;
                pulse_d     = 1'b1;
                brake_d     = BRAKES_OFF;
                brake_cnt_d = '0;
                alt_d       = 1'b0;
            end else begin
                case (lock_q)
                    UNLOCKED: begin
                        case (brake_q)
                            BRAKES_OFF: begin
                                if (reversal) begin
                                    brake_d     = BRAKING;
                                    brake_cnt_d = '0;
                                end else begin
                                    coarse_go = 1'b1;
                                end
                            end
                            BRAKING: begin
                                if (brake_cnt_q == BRAKE_LAST) begin
                                    brake_d     = RECOVERING;
                                    brake_cnt_d = '0;
                                    alt_d       = 1'b0;
                                end else begin
                                    brake_cnt_d = brake_cnt_q + 1'b1;
                                end
                            end
                            RECOVERING: begin
                                alt_d = ~alt_q;
                                if (reversal) begin
                                    brake_d     = BRAKING;
                                    brake_cnt_d = '0;
                                end else begin
                                    coarse_go = alt_q;
                                    if (ferr_mag <= MAG_W'(COARSE_TOL))
                                        brake_d = BRAKES_OFF;
                                end
                            end
                            default: brake_d = BRAKES_OFF;
                        endcase
                        if (coarse_go)
                            coarse_d = COARSE_W'(sat_step(CODE_W'(coarse_q),
                                CODE_W'({COARSE_W{1'b1}}), ferr_neg, ferr_pos));
                        if (run_done) begin
                            lock_d      = COARSE_FREQ_LOCKED;
                            brake_d     = BRAKES_OFF;
                            brake_cnt_d = '0;
                            alt_d       = 1'b0;
                        end
                    end
                    COARSE_FREQ_LOCKED: begin
                        fine_d = FINE_W'(sat_step(CODE_W'(fine_q),
                            CODE_W'({FINE_W{1'b1}}), ferr_neg, ferr_pos));
                        if (run_done)
                            lock_d = FINE_FREQ_LOCKED;
                    end
                    FINE_FREQ_LOCKED: begin
                        fine_d = FINE_W'(sat_step(CODE_W'(fine_q),
                            CODE_W'({FINE_W{1'b1}}), perr_neg, perr_pos));
                        if (run_done)
                            lock_d = PHASE_LOCKED;
                    end
                    default: begin
                        fine_d = FINE_W'(sat_step(CODE_W'(fine_q),
                            CODE_W'({FINE_W{1'b1}}), perr_neg, perr_pos));
                    end
                endcase
            end
        end
        locked_d = (lock_d == PHASE_LOCKED);
    end

    always_ff @(posedge refclk) begin
        if (!resetn) begin
            coarse_q    <= COARSE_MID;
            fine_q      <= FINE_MID;
            lock_q      <= UNLOCKED;
            brake_q     <= BRAKES_OFF;
            brake_cnt_q <= '0;
            alt_q       <= 1'b0;
            sign_vld_q  <= 1'b0;
            sign_neg_q  <= 1'b0;
            locked_q    <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            coarse_q    <= coarse_d;
            fine_q      <= fine_d;
            lock_q      <= lock_d;
            brake_q     <= brake_d;
            brake_cnt_q <= brake_cnt_d;
            alt_q       <= alt_d;
            sign_vld_q  <= sign_vld_d;
            sign_neg_q  <= sign_neg_d;
            locked_q    <= locked_d;
            pulse_q     <= pulse_d;
        end
    end

    assign bus.coarse_code  = coarse_q;
    assign bus.fine_code    = fine_q;
    assign bus.lock_state   = lock_q;
    assign bus.brake_state  = brake_q;
    assign bus.locked       = locked_q;
    assign bus.unlock_pulse = pulse_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Parametrised acquisition and lock controller for the all-digital PLL, clocked in the reference domain. Each reference period it takes a frequency-error sample and a phase-error sample. From these it steps the coarse and fine DCO codes and walks the global `lock_state_t` sequence UNLOCKED → COARSE_FREQ_LOCKED → FINE_FREQ_LOCKED → PHASE_LOCKED. It adds overshoot braking (`brake_state_t`) and loss-of-lock detection, neither of which the current loop has. It sits between the error detectors and the DCO code inputs.

## Interface
- FERR_W, 12, width of signed frequency error (pclk counts per refclk period minus target)
- PERR_W, 8, width of signed phase error
- COARSE_W, 6, coarse DCO code width
- FINE_W, 8, fine DCO code width
- LOCK_CNT, 4, consecutive in-tolerance valid samples required to advance a lock state
- COARSE_TOL, 8, |ferr| tolerance for coarse lock
- FINE_TOL, 1, |ferr| tolerance for fine lock (must be < COARSE_TOL)
- PHASE_TOL, 2, |perr| tolerance for phase lock
- LOSS_TOL, 16, |ferr| above which any locked state drops to UNLOCKED
- BRAKE_CYCLES, 3, valid samples coarse updates are frozen while BRAKING
- refclk, in, 1, sole clock; all logic on rising edge
- resetn, in, 1, reset; synchronous, active-low
- en, in, 1, loop enable
- err_valid, in, 1, ferr/perr sample valid this cycle
- ferr, in, FERR_W, signed frequency error
- perr, in, PERR_W, signed phase error
- coarse_code, out, COARSE_W, coarse DCO code
- fine_code, out, FINE_W, fine DCO code
- lock_state, out, lock_state_t, current lock state
- brake_state, out, brake_state_t, current brake state
- locked, out, 1, high when lock_state == PHASE_LOCKED
- unlock_pulse, out, 1, one-cycle pulse on loss of lock

## Operation
- Reset (resetn low at an edge, including mid-acquisition): coarse_code = 2^(COARSE_W-1), fine_code = 2^(FINE_W-1), UNLOCKED, BRAKES_OFF, locked = 0, unlock_pulse = 0, counters and stored ferr sign cleared.
- en low: codes hold, lock_state forced to UNLOCKED, brake_state forced to BRAKES_OFF, counters cleared, no unlock_pulse.
- Only cycles with en && err_valid update state. Magnitudes are computed one bit wider than the input, so ferr = −2^(FERR_W−1) is handled correctly. Codes saturate at 0 and at all-ones, with no wrap.
- UNLOCKED: coarse_code −1 if ferr > 0, +1 if ferr < 0, unchanged if 0. Gated by brake logic. Advances after LOCK_CNT consecutive samples with |ferr| ≤ COARSE_TOL.
- COARSE_FREQ_LOCKED: coarse frozen. fine_code is stepped by sign of ferr. Advances after LOCK_CNT consecutive samples with |ferr| ≤ FINE_TOL.
- FINE_FREQ_LOCKED: fine_code is stepped by sign of perr (perr > 0 → −1). Advances after LOCK_CNT consecutive samples with |perr| ≤ PHASE_TOL.
- PHASE_LOCKED: fine_code continues to track perr; coarse_code stays frozen.
- Counter: an out-of-tolerance sample clears it to 0. It also clears on every state change.
- Loss of lock: from any state except UNLOCKED, a single sample with |ferr| > LOSS_TOL causes the following:
  - lock_state → UNLOCKED.
  - fine_code → midscale.
  - unlock_pulse high for one cycle.
  - Loss has priority over advance in the same sample.
- Brakes (UNLOCKED only; forced to BRAKES_OFF in other states):
  - BRAKES_OFF: if a nonzero ferr has the opposite sign to the last nonzero ferr, go to BRAKING. The coarse step for that sample is suppressed.
  - BRAKING: no coarse updates for BRAKE_CYCLES valid samples, then go to RECOVERING.
  - RECOVERING: coarse updates only on every second valid sample. If |ferr| ≤ COARSE_TOL, go to BRAKES_OFF. If another sign reversal occurs, go back to BRAKING; this takes priority.
  - The lock counter still runs while braking.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Code and state changes from a valid sample at edge N are visible after edge N+1 (latency 1).
- locked follows lock_state in the same cycle. unlock_pulse is asserted in the same cycle lock_state becomes UNLOCKED.
- The LOCK_CNT-th qualifying sample causes the transition at that sample's update edge.

## Structure
- `lock_state_t` and `brake_state_t` stay in the shared global params package. Add no duplicates.
- Add a shared `localparam`-style default for LOCK_CNT beside `NUM_STAGES`/KDCO defines only if another block consumes it; otherwise keep it as a parameter.
- One natural sub-module: `tol_run_counter` (magnitude compare plus saturating consecutive-hit counter). It is instantiated once per lock stage or muxed by state.

## Test plan
- Reset with ferr = +40 valid every cycle → coarse_code goes 32, 31, 30, … one step per cycle; lock_state stays UNLOCKED; brake_state = BRAKES_OFF.
- ferr sequence +20, +10, −6 → BRAKING on the −6 sample, coarse unchanged for 3 valid samples, then RECOVERING with updates on alternate samples; |ferr| ≤ 8 → BRAKES_OFF.
- ferr = 3 for 4 valid samples from UNLOCKED → COARSE_FREQ_LOCKED on the 4th; then ferr = 0 ×4 → FINE_FREQ_LOCKED; then perr = 1 ×4 → PHASE_LOCKED, locked = 1.
- In PHASE_LOCKED, drive ferr = −17 once → next edge UNLOCKED, unlock_pulse = 1 for one cycle, fine_code = 128, coarse_code unchanged.
- Drive coarse_code to 0 with ferr = +100 held → stays 0 with no wrap. Drive ferr = −2048 → treated as large negative, and coarse increments.
- Assert resetn low mid-BRAKING → all outputs return to reset values at that edge. en low in PHASE_LOCKED → UNLOCKED with no unlock_pulse, and codes held.
